alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Drives operands/control into a combinational 4-bit ALU, waits a
//            settle time, captures the result; single-op or 8-op sweep mode.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_SWEEP,
    input  logic [2:0] CMD_OP,
    input  logic [3:0] CMD_A,
    input  logic [3:0] CMD_B,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       M,
    output logic       S1,
    output logic       S0,
    input  logic       F0,
    input  logic       F1,
    input  logic       F2,
    input  logic       F3,
    input  logic       CiOut,
    output logic       RES_VALID,
    input  logic       RES_READY,
    output logic [3:0] RES_F,
    output logic       RES_CO,
    output logic [2:0] RES_OP,
    output logic       RES_LAST
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    localparam logic [3:0] C_SETTLE_CNT = 4'(SETTLE);

    state_t     state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic       sweep_q,     sweep_d;
    logic       cmd_ready_q, cmd_ready_d;
    logic [3:0] a_q,         a_d;
    logic [3:0] b_q,         b_d;
    logic [2:0] op_q,        op_d;
    logic       res_valid_q, res_valid_d;
    logic [3:0] res_f_q,     res_f_d;
    logic       res_co_q,    res_co_d;
    logic [2:0] res_op_q,    res_op_d;
    logic       res_last_q,  res_last_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_d     = sweep_q;
        cmd_ready_d = cmd_ready_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        res_valid_d = res_valid_q;
        res_f_d     = res_f_q;
        res_co_d    = res_co_q;
        res_op_d    = res_op_q;
        res_last_d  = res_last_q;

        case (state_q)
            ST_IDLE: begin
                // Ready comes up one edge after reset release, then stays up while idle.
                cmd_ready_d = 1'b1;
                if (CMD_VALID && cmd_ready_q) begin
                    a_d         = CMD_A;
                    b_d         = CMD_B;
                    op_d        = CMD_SWEEP ? 3'b000 : CMD_OP;
                    sweep_d     = CMD_SWEEP;
                    cnt_d       = C_SETTLE_CNT;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    res_f_d     = {F3, F2, F1, F0};
                    res_co_d    = CiOut;
                    res_op_d    = op_q;
                    res_last_d  = !sweep_q || (op_q == 3'b111);
                    res_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = ST_RESULT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESULT: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    if (sweep_q && (op_q != 3'b111)) begin
                        op_d    = op_q + 3'd1;
                        cnt_d   = C_SETTLE_CNT;
                        state_d = ST_WAIT;
                    end else begin
                        sweep_d     = 1'b0;
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                cmd_ready_d = 1'b0;
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            sweep_q     <= 1'b0;
            cmd_ready_q <= 1'b0;
            a_q         <= 4'd0;
            b_q         <= 4'd0;
            op_q        <= 3'd0;
            res_valid_q <= 1'b0;
            res_f_q     <= 4'd0;
            res_co_q    <= 1'b0;
            res_op_q    <= 3'd0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sweep_q     <= sweep_d;
            cmd_ready_q <= cmd_ready_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_valid_q <= res_valid_d;
            res_f_q     <= res_f_d;
            res_co_q    <= res_co_d;
            res_op_q    <= res_op_d;
            res_last_q  <= res_last_d;
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign A         = a_q;
    assign B         = b_q;
    assign M         = op_q[2];
    assign S1        = op_q[1];
    assign S0        = op_q[0];
    assign RES_VALID = res_valid_q;
    assign RES_F     = res_f_q;
    assign RES_CO    = res_co_q;
    assign RES_OP    = res_op_q;
    assign RES_LAST  = res_last_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Self-checking bench; three sequencers (SETTLE 2, 1, 15) on XOR ALU stubs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst       [3];
    logic       cmd_valid [3];
    logic       cmd_ready [3];
    logic       cmd_sweep [3];
    logic [2:0] cmd_op    [3];
    logic [3:0] cmd_a     [3];
    logic [3:0] cmd_b     [3];
    logic [3:0] a_o       [3];
    logic [3:0] b_o       [3];
    logic       m_o       [3];
    logic       s1_o      [3];
    logic       s0_o      [3];
    logic [3:0] f_in      [3];
    logic       co_in     [3];
    logic       res_valid [3];
    logic       res_ready [3];
    logic [3:0] res_f     [3];
    logic       res_co    [3];
    logic [2:0] res_op    [3];
    logic       res_last  [3];

    int st_of [3] = '{2, 1, 15};
    int n_checks = 0;
    int n_pass   = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int ST = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);
        assign f_in[gi]  = a_o[gi] ^ b_o[gi];
        assign co_in[gi] = a_o[gi][3] & b_o[gi][3];
        alu_op_sequencer #(.SETTLE(ST)) u_dut (
            .CLK      (clk),
            .RST      (rst[gi]),
            .CMD_VALID(cmd_valid[gi]),
            .CMD_READY(cmd_ready[gi]),
            .CMD_SWEEP(cmd_sweep[gi]),
            .CMD_OP   (cmd_op[gi]),
            .CMD_A    (cmd_a[gi]),
            .CMD_B    (cmd_b[gi]),
            .A        (a_o[gi]),
            .B        (b_o[gi]),
            .M        (m_o[gi]),
            .S1       (s1_o[gi]),
            .S0       (s0_o[gi]),
            .F0       (f_in[gi][0]),
            .F1       (f_in[gi][1]),
            .F2       (f_in[gi][2]),
            .F3       (f_in[gi][3]),
            .CiOut    (co_in[gi]),
            .RES_VALID(res_valid[gi]),
            .RES_READY(res_ready[gi]),
            .RES_F    (res_f[gi]),
            .RES_CO   (res_co[gi]),
            .RES_OP   (res_op[gi]),
            .RES_LAST (res_last[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one command and walks every result it produces against the model.
    // abort_at >= 0 returns right after that result index has been checked.
    task automatic run_cmd(input int d, input logic sweep, input logic [2:0] op,
                           input logic [3:0] a, input logic [3:0] b,
                           input int stall_lo, input int stall_hi, input int abort_at);
        int         lat;
        int         stall;
        int         nres;
        logic [2:0] eop;
        logic       elast;
        logic [3:0] ef;
        logic       eco;
        ef   = a ^ b;
        eco  = a[3] & b[3];
        nres = sweep ? 8 : 1;
        lat  = 0;
        while (!cmd_ready[d] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (cmd_ready[d] !== 1'b1) $display("FAIL ready_before_cmd[%0d]: got %b want 1", d, cmd_ready[d]);
        else n_pass++;
        cmd_valid[d] = 1'b1;
        cmd_sweep[d] = sweep;
        cmd_op[d]    = op;
        cmd_a[d]     = a;
        cmd_b[d]     = b;
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        cmd_sweep[d] = ~sweep;
        cmd_op[d]    = ~op;
        cmd_a[d]     = ~a;
        cmd_b[d]     = ~b;
        n_checks++;
        if (cmd_ready[d] !== 1'b0) $display("FAIL ready_after_accept[%0d]: got %b want 0", d, cmd_ready[d]);
        else n_pass++;
        for (int k = 0; k < nres; k++) begin
            eop   = sweep ? 3'(k) : op;
            elast = !sweep || (eop == 3'b111);
            n_checks++;
            if ({a_o[d], b_o[d], m_o[d], s1_o[d], s0_o[d]} !== {a, b, eop})
                $display("FAIL drive[%0d] k=%0d: got %h want %h", d, k,
                         {a_o[d], b_o[d], m_o[d], s1_o[d], s0_o[d]}, {a, b, eop});
            else n_pass++;
            lat = 0;
            while (!res_valid[d] && lat < 40) begin
                res_ready[d] = 1'($urandom_range(1, 0));
                @(negedge clk);
                lat++;
            end
            res_ready[d] = 1'b0;
            n_checks++;
            if (lat != st_of[d]) $display("FAIL latency[%0d] k=%0d: got %0d want %0d", d, k, lat, st_of[d]);
            else n_pass++;
            n_checks++;
            if ({res_f[d], res_co[d], res_op[d], res_last[d]} !== {ef, eco, eop, elast})
                $display("FAIL result[%0d] k=%0d: got %h want %h", d, k,
                         {res_f[d], res_co[d], res_op[d], res_last[d]}, {ef, eco, eop, elast});
            else n_pass++;
            if (k == abort_at) return;
            stall = $urandom_range(stall_hi, stall_lo);
            for (int s = 0; s < stall; s++) begin
                cmd_valid[d] = 1'($urandom_range(1, 0));
                cmd_a[d]     = 4'($urandom_range(15, 0));
                cmd_b[d]     = 4'($urandom_range(15, 0));
                @(negedge clk);
                n_checks++;
                if ({res_valid[d], res_f[d], res_co[d], res_op[d], res_last[d], a_o[d], b_o[d]}
                    !== {1'b1, ef, eco, eop, elast, a, b})
                    $display("FAIL hold[%0d] k=%0d s=%0d: got %h want %h", d, k, s,
                             {res_valid[d], res_f[d], res_co[d], res_op[d], res_last[d], a_o[d], b_o[d]},
                             {1'b1, ef, eco, eop, elast, a, b});
                else n_pass++;
            end
            cmd_valid[d] = 1'b0;
            res_ready[d] = 1'b1;
            @(negedge clk);
            res_ready[d] = 1'b0;
            n_checks++;
            if (res_valid[d] !== 1'b0) $display("FAIL valid_drop[%0d] k=%0d: got %b want 0", d, k, res_valid[d]);
            else n_pass++;
        end
        n_checks++;
        if (cmd_ready[d] !== 1'b1) $display("FAIL ready_after_cmd[%0d]: got %b want 1", d, cmd_ready[d]);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({cmd_ready[d], a_o[d], b_o[d], m_o[d], s1_o[d], s0_o[d], res_valid[d],
                 res_f[d], res_co[d], res_op[d], res_last[d]} !== 22'd0)
                $display("FAIL reset_outputs[%0d]: got %h want 0", d,
                         {cmd_ready[d], a_o[d], b_o[d], m_o[d], s1_o[d], s0_o[d], res_valid[d],
                          res_f[d], res_co[d], res_op[d], res_last[d]});
            else n_pass++;
            rst[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (cmd_ready[d] !== 1'b0) $display("FAIL ready_before_edge[%0d]: got %b want 0", d, cmd_ready[d]);
            else n_pass++;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (cmd_ready[d] !== 1'b1) $display("FAIL ready_first_edge[%0d]: got %b want 1", d, cmd_ready[d]);
            else n_pass++;
        end
    endtask

    task automatic test_single_directed();
        run_cmd(0, 1'b0, 3'b011, 4'b0101, 4'b0100, 0, 0, -1);
    endtask

    task automatic test_sweep_directed();
        run_cmd(0, 1'b1, 3'b000, 4'b1010, 4'b0101, 0, 0, -1);
    endtask

    task automatic test_backpressure();
        run_cmd(0, 1'b0, 3'b110, 4'b1100, 4'b1010, 5, 5, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            run_cmd(0, ($urandom_range(3, 0) == 0), 3'($urandom_range(7, 0)),
                    4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 0, 3, -1);
    endtask

    task automatic test_reset_mid_sweep();
        logic seen;
        run_cmd(0, 1'b1, 3'b000, 4'b1001, 4'b1011, 0, 1, 3);
        #2 rst[0] = 1'b1;
        #1;
        n_checks++;
        if ({cmd_ready[0], a_o[0], b_o[0], m_o[0], s1_o[0], s0_o[0], res_valid[0],
             res_f[0], res_co[0], res_op[0], res_last[0]} !== 22'd0)
            $display("FAIL midsweep_reset_outputs: got %h want 0",
                     {cmd_ready[0], a_o[0], b_o[0], m_o[0], s1_o[0], s0_o[0], res_valid[0],
                      res_f[0], res_co[0], res_op[0], res_last[0]});
        else n_pass++;
        #1 rst[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid[0] !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL midsweep_no_result: got %b want 0", seen);
        else n_pass++;
        run_cmd(0, 1'b0, 3'b101, 4'b0110, 4'b1110, 0, 2, -1);
    endtask

    task automatic test_settle_extremes();
        for (int d = 1; d < 3; d++) begin
            run_cmd(d, 1'b0, 3'($urandom_range(7, 0)), 4'($urandom_range(15, 0)),
                    4'($urandom_range(15, 0)), 0, 2, -1);
            run_cmd(d, 1'b1, 3'b000, 4'($urandom_range(15, 0)),
                    4'($urandom_range(15, 0)), 0, 1, -1);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d]       = 1'b0;
            cmd_valid[d] = 1'b0;
            cmd_sweep[d] = 1'b0;
            cmd_op[d]    = 3'd0;
            cmd_a[d]     = 4'd0;
            cmd_b[d]     = 4'd0;
            res_ready[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        test_reset();
        test_single_directed();
        test_sweep_directed();
        test_backpressure();
        test_random();
        test_reset_mid_sweep();
        test_settle_extremes();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
